// File: rtl/board_reset_status.sv
// Board reset sequencer: synchronises reset release, waits for a stable PLL lock, then drives status LEDs.
// Optional heartbeat LED is built only when HEARTBEAT_EN is defined.
module board_reset_status #(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_FLAGS     = 4,
  parameter int CLK_FREQ      = 100_000_000,
  parameter int STRETCH_MS    = 50,
  parameter int LOCK_WAIT_CYC = 1024,
  parameter int HB_HZ         = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pll_locked_i,
  input  logic [NUM_FLAGS-1:0] flag_i,
  input  logic [NUM_FLAGS-1:0] sticky_i,
  input  logic                 clr_i,
  output logic                 sys_rst_o,
  output logic                 rst_done_o,
  output logic [NUM_FLAGS-1:0] led_o,
  output logic                 any_err_o,
  output logic                 hb_led_o
);

  localparam int STRETCH_CYC = CLK_FREQ / 1000 * STRETCH_MS;
  localparam int SW          = $clog2(STRETCH_CYC + 1);
  localparam int LW          = $clog2(LOCK_WAIT_CYC + 1);

  generate
    if ((SYNC_STAGES < 2) || (NUM_FLAGS < 1) || (NUM_FLAGS > 16) || ((CLK_FREQ % 1000) != 0) ||
        (STRETCH_CYC < 1) || (LOCK_WAIT_CYC < 1) || (HB_HZ < 1)) begin : g_param_check
      $error("board_reset_status: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t                       state_r;
  logic [SYNC_STAGES-1:0]       sync_r;
  logic                         lock_meta_r;
  logic                         lock_s_r;
  logic [LW-1:0]                lock_cnt_r;
  logic [NUM_FLAGS-1:0][SW-1:0] cnt_r;
  logic [NUM_FLAGS-1:0][SW-1:0] cnt_next_s;
  logic [NUM_FLAGS-1:0]         led_r;
  logic [NUM_FLAGS-1:0]         led_next_s;
  logic                         any_r;
  logic                         run_s;

  assign run_s = (state_r == ST_RUN);

  // reset-release synchroniser: ones ripple in once rst_i drops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_r <= '0;
    else       sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
  end

  // two-stage synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_meta_r <= 1'b0;
      lock_s_r    <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked_i;
      lock_s_r    <= lock_meta_r;
    end
  end

  // sequencer FSM: any lock loss restarts the lock-stability count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_HOLD;
      lock_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (sync_r[SYNC_STAGES-1]) begin
            state_r    <= ST_WAIT_LOCK;
            lock_cnt_r <= '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (!lock_s_r) begin
            lock_cnt_r <= '0;
          end else if (lock_cnt_r == LW'(LOCK_WAIT_CYC - 1)) begin
            state_r    <= ST_RUN;
            lock_cnt_r <= '0;
          end else begin
            lock_cnt_r <= lock_cnt_r + LW'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s_r) begin
            state_r    <= ST_WAIT_LOCK;
            lock_cnt_r <= '0;
          end
        end
        default: begin
          state_r    <= ST_HOLD;
          lock_cnt_r <= '0;
        end
      endcase
    end
  end

  assign sys_rst_o  = (state_r != ST_RUN);
  assign rst_done_o = (state_r == ST_RUN);

  // next indicator state; a flag in the same cycle as clr_i wins
  always_comb begin
    for (int i = 0; i < NUM_FLAGS; i++) begin
      cnt_next_s[i] = '0;
      led_next_s[i] = 1'b0;
      if (run_s) begin
        if (sticky_i[i]) begin
          led_next_s[i] = flag_i[i] | (led_r[i] & ~clr_i);
        end else begin
          if (flag_i[i])              cnt_next_s[i] = SW'(STRETCH_CYC);
          else if (clr_i)             cnt_next_s[i] = '0;
          else if (cnt_r[i] != '0)    cnt_next_s[i] = cnt_r[i] - SW'(1);
          else                        cnt_next_s[i] = '0;
          led_next_s[i] = (cnt_next_s[i] != '0);
        end
      end else begin
        cnt_next_s[i] = '0;
        led_next_s[i] = 1'b0;
      end
    end
  end

  // indicator registers; any_err tracks the same next value so it lines up with led_o
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= '0;
      led_r <= '0;
      any_r <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      led_r <= led_next_s;
      any_r <= |led_next_s;
    end
  end

  assign led_o     = led_r;
  assign any_err_o = any_r;

`ifdef HEARTBEAT_EN
  localparam int HB_HALF = CLK_FREQ / (2 * HB_HZ);
  localparam int HW      = $clog2(HB_HALF + 1);

  logic [HW-1:0] hb_cnt_r;
  logic          hb_r;

  // heartbeat half-period counter, parked at zero outside RUN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hb_cnt_r <= '0;
      hb_r     <= 1'b0;
    end else if (!run_s) begin
      hb_cnt_r <= '0;
      hb_r     <= 1'b0;
    end else if (hb_cnt_r == HW'(HB_HALF - 1)) begin
      hb_cnt_r <= '0;
      hb_r     <= ~hb_r;
    end else begin
      hb_cnt_r <= hb_cnt_r + HW'(1);
    end
  end

  assign hb_led_o = hb_r;
`else
  assign hb_led_o = 1'b0;
`endif

endmodule

// File: tb/tb_board_reset_status.sv
// Self-checking bench for board_reset_status: directed table, hand sequences and a randomized
// run compared against a window/timestamp reference model.
module tb_board_reset_status;

  localparam int NF        = 4;
  localparam int SYNC      = 2;
  localparam int LOCK_WAIT = 16;
  localparam int STRETCH   = 10;
  localparam int HB_HALF   = 10;
  localparam int RELEASE   = SYNC + 1 + LOCK_WAIT;
  localparam int NEG       = -1000000;
  localparam int HMAX      = 4096;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          pll_locked_i;
  logic [NF-1:0] flag_i;
  logic [NF-1:0] sticky_i;
  logic          clr_i;
  logic          sys_rst_o;
  logic          rst_done_o;
  logic [NF-1:0] led_o;
  logic          any_err_o;
  logic          hb_led_o;

  board_reset_status #(
    .SYNC_STAGES  (SYNC),
    .NUM_FLAGS    (NF),
    .CLK_FREQ     (1000),
    .STRETCH_MS   (10),
    .LOCK_WAIT_CYC(LOCK_WAIT),
    .HB_HZ        (50)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pll_locked_i(pll_locked_i),
    .flag_i      (flag_i),
    .sticky_i    (sticky_i),
    .clr_i       (clr_i),
    .sys_rst_o   (sys_rst_o),
    .rst_done_o  (rst_done_o),
    .led_o       (led_o),
    .any_err_o   (any_err_o),
    .hb_led_o    (hb_led_o)
  );

  always #5 clk_i = ~clk_i;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // reference model: edge index since reset release, sampled lock history, event timestamps
  int t;
  bit hist [HMAX];
  int last_flag [NF];
  int last_clr;
  int hb_k;

  typedef struct {
    logic [NF-1:0] flag;
    logic          clr;
    int            reps;
    logic [NF-1:0] led;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, t);
    end
  endtask

  // core is out of reset after edge tt iff the reset-release latency has passed and
  // the last LOCK_WAIT lock samples seen by the sequencer were all high
  function automatic bit run_at(input int tt);
    if (tt < RELEASE) return 1'b0;
    for (int k = tt - LOCK_WAIT - 1; k <= tt - 2; k++)
      if (!hist[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NF-1:0] exp_led();
    logic [NF-1:0] e;
    for (int i = 0; i < NF; i++)
      e[i] = (last_flag[i] != NEG) && (last_flag[i] >= last_clr) &&
             (sticky_i[i] || ((t - last_flag[i]) < STRETCH));
    return e;
  endfunction

  function automatic logic exp_hb();
`ifdef HEARTBEAT_EN
    return (hb_k > 0) ? logic'(((hb_k / HB_HALF) % 2) == 1) : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    t = 0;
    for (int k = 0; k < HMAX; k++) hist[k] = 1'b0;
    for (int i = 0; i < NF; i++) last_flag[i] = NEG;
    last_clr = NEG;
    hb_k     = 0;
  endtask

  task automatic step(input logic [NF-1:0] f, input logic c);
    bit run_prev;
    flag_i = f;
    clr_i  = c;
    @(posedge clk_i);
    t++;
    if (t < HMAX) hist[t] = pll_locked_i;
    run_prev = run_at(t - 1);
    if (!run_prev) begin
      for (int i = 0; i < NF; i++) last_flag[i] = NEG;
      last_clr = NEG;
      hb_k     = 0;
    end else begin
      hb_k++;
      if (c) last_clr = t;
      for (int i = 0; i < NF; i++)
        if (f[i]) last_flag[i] = t;
    end
    #1;
  endtask

  task automatic check_model();
    logic [NF-1:0] el;
    el = exp_led();
    chk("model_sys_rst", sys_rst_o, !run_at(t));
    chk("model_rst_done", rst_done_o, run_at(t));
    chk("model_led", led_o, el);
    chk("model_any_err", any_err_o, |el);
    chk("model_hb", hb_led_o, exp_hb());
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_clear();
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 1'b0,   1, 4'b0001};
    tbl[1]  = '{4'b0000, 1'b0,   9, 4'b0001};
    tbl[2]  = '{4'b0000, 1'b0,   2, 4'b0000};
    tbl[3]  = '{4'b0001, 1'b0,   1, 4'b0001};
    tbl[4]  = '{4'b0000, 1'b0,   5, 4'b0001};
    tbl[5]  = '{4'b0001, 1'b0,   1, 4'b0001};
    tbl[6]  = '{4'b0000, 1'b0,   9, 4'b0001};
    tbl[7]  = '{4'b0000, 1'b0,   1, 4'b0000};
    tbl[8]  = '{4'b0010, 1'b0,   1, 4'b0010};
    tbl[9]  = '{4'b0000, 1'b0, 100, 4'b0010};
    tbl[10] = '{4'b0000, 1'b1,   1, 4'b0000};
    tbl[11] = '{4'b0000, 1'b0,   2, 4'b0000};
    tbl[12] = '{4'b0010, 1'b1,   1, 4'b0010};
    tbl[13] = '{4'b0000, 1'b0,   3, 4'b0010};
    tbl[14] = '{4'b0001, 1'b0,   1, 4'b0011};
    tbl[15] = '{4'b0000, 1'b0,   2, 4'b0011};
    tbl[16] = '{4'b0000, 1'b1,   1, 4'b0000};
    tbl[17] = '{4'b0100, 1'b1,   1, 4'b0100};
    tbl[18] = '{4'b1000, 1'b0,   1, 4'b1100};
    tbl[19] = '{4'b0000, 1'b1,   1, 4'b0000};

    rst_i        = 1'b1;
    pll_locked_i = 1'b1;
    flag_i       = '0;
    clr_i        = 1'b0;
    sticky_i     = 4'b1010;
    model_clear();

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_sys_rst", sys_rst_o, 1'b1);
    chk("reset_rst_done", rst_done_o, 1'b0);
    chk("reset_led", led_o, 4'b0000);
    chk("reset_any_err", any_err_o, 1'b0);
    chk("reset_hb", hb_led_o, 1'b0);

    // release latency with lock held
    release_reset();
    for (int k = 1; k < RELEASE; k++) step('0, 1'b0);
    chk("release_edge18_sys_rst", sys_rst_o, 1'b1);
    chk("release_edge18_done", rst_done_o, 1'b0);
    step('0, 1'b0);
    chk("release_edge19_sys_rst", sys_rst_o, 1'b0);
    chk("release_edge19_done", rst_done_o, 1'b1);

    // indicator vector table (ch1/ch3 sticky, ch0/ch2 stretch)
    for (int v = 0; v < 20; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        step(tbl[v].flag, tbl[v].clr);
        chk("tbl_led", led_o, tbl[v].led);
        chk("tbl_any_err", any_err_o, |tbl[v].led);
      end
    end

    // one-cycle lock drop in RUN
    pll_locked_i = 1'b0;
    step('0, 1'b0);
    pll_locked_i = 1'b1;
    chk("drop_d0_sys_rst", sys_rst_o, 1'b0);
    step('0, 1'b0);
    chk("drop_d1_sys_rst", sys_rst_o, 1'b0);
    step('0, 1'b0);
    chk("drop_d2_sys_rst", sys_rst_o, 1'b1);
    chk("drop_d2_done", rst_done_o, 1'b0);
    repeat (15) step('0, 1'b0);
    chk("relock_d17_sys_rst", sys_rst_o, 1'b1);
    step('0, 1'b0);
    chk("relock_d18_sys_rst", sys_rst_o, 1'b0);
    chk("relock_d18_done", rst_done_o, 1'b1);

    // async reset with LEDs lit
    step(4'b1111, 1'b0);
    chk("lit_led", led_o, 4'b1111);
    chk("lit_any_err", any_err_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_sys_rst", sys_rst_o, 1'b1);
    chk("async_rst_done", rst_done_o, 1'b0);
    chk("async_rst_led", led_o, 4'b0000);
    chk("async_rst_any_err", any_err_o, 1'b0);
    release_reset();

    // async reset during WAIT_LOCK, then full re-release checked against the model
    repeat (10) step('0, 1'b0);
    chk("wait_lock_sys_rst", sys_rst_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("wait_lock_rst_sys_rst", sys_rst_o, 1'b1);
    chk("wait_lock_rst_done", rst_done_o, 1'b0);
    release_reset();
    repeat (25) begin
      step('0, 1'b0);
      check_model();
    end

    // randomized blocks, each started from a fresh reset with a new static mode mask
    for (int blk = 0; blk < 3; blk++) begin
      rst_i    = 1'b1;
      sticky_i = 4'($urandom_range(0, 15));
      release_reset();
      for (int n = 0; n < 1000; n++) begin
        logic [NF-1:0] f;
        logic          c;
        pll_locked_i = ($urandom_range(0, 59) != 0);
        for (int i = 0; i < NF; i++) f[i] = ($urandom_range(0, 11) == 0);
        c = ($urandom_range(0, 29) == 0);
        step(f, c);
        check_model();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
